// File: rtl/bol_video_rx_pkg.sv
// Shared defaults and FSM state encoding for the bolometer video receiver.
package bol_video_rx_pkg;

    localparam int ADC_W_DEF         = 14;
    localparam int WORDS_PER_ROW_DEF = 192;
    localparam int ROWS_DEF          = 288;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_ROW  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/bol_rx_fifo.sv
// First-word fall-through FIFO: read data is valid whenever empty_o is low.
// A write into a full FIFO is accepted only if a read frees a slot in the same cycle.
module bol_rx_fifo #(
    parameter int W     = 30,
    parameter int DEPTH = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_dat_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_wr, do_rd;

    assign empty_o  = (cnt_q == '0);
    assign full_o   = (cnt_q == CW'(DEPTH));
    assign do_rd    = rd_en_i & ~empty_o;
    assign do_wr    = wr_en_i & (~full_o | do_rd);
    assign rd_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/bol_video_rx.sv
// Bolometer video receiver: delay-aligns ADC words to DATAVALID, checks row/frame geometry, packs
// two channels per word into a FWFT FIFO. Optional ramp source on TESTPAT with BOL_VIDEO_RX_TESTPAT_EN.
module bol_video_rx
    import bol_video_rx_pkg::*;
#(
    parameter int ADC_W         = ADC_W_DEF,
    parameter int DATA_DELAY    = 10,
    parameter int WORDS_PER_ROW = WORDS_PER_ROW_DEF,
    parameter int ROWS          = ROWS_DEF,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               DATAVALID,
    input  logic               LINE1,
    input  logic [ADC_W-1:0]   ADC_IN1,
    input  logic [ADC_W-1:0]   ADC_IN2,
`ifdef BOL_VIDEO_RX_TESTPAT_EN
    input  logic               TESTPAT,
`endif
    output logic [2*ADC_W-1:0] PIX_DATA,
    output logic               PIX_VALID,
    input  logic               PIX_READY,
    output logic               PIX_SOF,
    output logic               PIX_EOL,
    output logic [15:0]        FRAME_CNT,
    output logic               ERR_OVF,
    output logic               ERR_LEN,
    input  logic               ERR_CLR
);

    localparam int FW  = 2 * ADC_W + 2;
    localparam int WCW = $clog2(WORDS_PER_ROW + 1);
    localparam int RCW = $clog2(ROWS + 1);
    localparam logic [WCW-1:0] WPR_C  = WCW'(WORDS_PER_ROW);
    localparam logic [RCW-1:0] ROWS_C = RCW'(ROWS);

    // Bit 0 is the input register; bit DATA_DELAY lines up with the registered ADC words.
    logic [DATA_DELAY:0] dv_sr_q, l1_sr_q;
    logic                dv_p_q, l1_p_q;
    logic [ADC_W-1:0]    adc1_q, adc2_q;
    state_t              state_q;
    logic [WCW-1:0]      word_cnt_q;
    logic [RCW-1:0]      row_cnt_q;
    logic [15:0]         frame_cnt_q;
    logic                err_len_q, err_ovf_q;

    logic dv_d, l1_d, dv_rise, l1_rise;
    logic new_frame, new_row, row_word, wr_req, wr_sof, wr_eol;
    logic len_set, ovf_set, err_len_d, err_ovf_d;
    logic fifo_full, fifo_empty;
    logic [WCW-1:0]   word_idx;
    logic [ADC_W-1:0] px1, px2;
    logic [FW-1:0]    rd_dat;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dv_sr_q <= '0;
            l1_sr_q <= '0;
            dv_p_q  <= 1'b0;
            l1_p_q  <= 1'b0;
            adc1_q  <= '0;
            adc2_q  <= '0;
        end else begin
            dv_sr_q <= {dv_sr_q[DATA_DELAY-1:0], DATAVALID};
            l1_sr_q <= {l1_sr_q[DATA_DELAY-1:0], LINE1};
            dv_p_q  <= dv_d;
            l1_p_q  <= l1_d;
            adc1_q  <= ADC_IN1;
            adc2_q  <= ADC_IN2;
        end
    end

    assign dv_d    = dv_sr_q[DATA_DELAY];
    assign l1_d    = l1_sr_q[DATA_DELAY];
    assign dv_rise = dv_d & ~dv_p_q;
    assign l1_rise = l1_d & ~l1_p_q;

    // The first word of a row is captured in the same cycle the row is recognised.
    assign new_frame = l1_rise & (state_q != ST_ROW);
    assign new_row   = new_frame | ((state_q == ST_GAP) & dv_rise & (row_cnt_q != ROWS_C));
    assign row_word  = (state_q == ST_ROW) & dv_d & (word_cnt_q != WPR_C);
    assign wr_req    = new_row | row_word;
    assign word_idx  = new_row ? '0 : word_cnt_q;
    assign wr_sof    = new_frame;
    assign wr_eol    = (word_idx == WPR_C - WCW'(1));

`ifdef BOL_VIDEO_RX_TESTPAT_EN
    logic tp_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) tp_q <= 1'b0;
        else       tp_q <= TESTPAT;
    end
    assign px1 = tp_q ? ADC_W'({word_idx, 1'b0}) : adc1_q;
    assign px2 = tp_q ? ADC_W'({word_idx, 1'b1}) : adc2_q;
`else
    assign px1 = adc1_q;
    assign px2 = adc2_q;
`endif

    assign len_set = ((state_q == ST_ROW) & ~dv_d & (word_cnt_q != WPR_C))
                   | ((state_q == ST_ROW) & dv_d & (word_cnt_q == WPR_C))
                   | ((state_q == ST_GAP) & l1_rise & (row_cnt_q != ROWS_C))
                   | ((state_q == ST_GAP) & dv_rise & ~l1_d & (row_cnt_q == ROWS_C));
    assign ovf_set   = wr_req & fifo_full & ~PIX_READY;
    assign err_len_d = ERR_CLR ? 1'b0 : (err_len_q | len_set);
    assign err_ovf_d = ERR_CLR ? 1'b0 : (err_ovf_q | ovf_set);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_SYNC;
            word_cnt_q  <= '0;
            row_cnt_q   <= '0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            err_len_q <= err_len_d;
            err_ovf_q <= err_ovf_d;
            case (state_q)
                ST_SYNC: begin
                    if (new_frame) begin
                        state_q    <= ST_ROW;
                        row_cnt_q  <= '0;
                        word_cnt_q <= WCW'(1);
                    end
                end
                ST_ROW: begin
                    if (!dv_d) begin
                        state_q    <= ST_GAP;
                        row_cnt_q  <= row_cnt_q + RCW'(1);
                        word_cnt_q <= '0;
                    end else if (row_word) begin
                        word_cnt_q <= word_cnt_q + WCW'(1);
                    end
                end
                ST_GAP: begin
                    if (row_cnt_q == ROWS_C) frame_cnt_q <= frame_cnt_q + 16'd1;
                    if (new_frame) begin
                        state_q    <= ST_ROW;
                        row_cnt_q  <= '0;
                        word_cnt_q <= WCW'(1);
                    end else if (new_row) begin
                        state_q    <= ST_ROW;
                        word_cnt_q <= WCW'(1);
                    end else if (row_cnt_q == ROWS_C) begin
                        state_q <= ST_SYNC;
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

    bol_rx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .wr_en_i  (wr_req),
        .wr_dat_i ({px2, px1, wr_sof, wr_eol}),
        .rd_en_i  (PIX_READY),
        .rd_dat_o (rd_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    // Memory contents are undefined after reset, so outputs are forced low while empty.
    assign PIX_VALID = ~fifo_empty;
    assign PIX_DATA  = fifo_empty ? '0 : rd_dat[FW-1:2];
    assign PIX_SOF   = ~fifo_empty & rd_dat[1];
    assign PIX_EOL   = ~fifo_empty & rd_dat[0];
    assign FRAME_CNT = frame_cnt_q;
    assign ERR_LEN   = err_len_q;
    assign ERR_OVF   = err_ovf_q;

endmodule

// File: tb/tb_bol_video_rx.sv
// Randomised scoreboard bench for bol_video_rx with a row/frame-level reference model.
module tb_bol_video_rx;

    localparam int ADC_W = 14;
    localparam int DLY   = 10;
    localparam int WPR   = 8;
    localparam int NROWS = 4;
    localparam int DEPTH = 4;

    typedef logic [2*ADC_W+1:0] exp_t;

    logic               CLK = 1'b0;
    logic               RESET, DATAVALID, LINE1, PIX_READY, ERR_CLR;
    logic [ADC_W-1:0]   ADC_IN1, ADC_IN2;
    logic [2*ADC_W-1:0] PIX_DATA;
    logic               PIX_VALID, PIX_SOF, PIX_EOL, ERR_OVF, ERR_LEN;
    logic [15:0]        FRAME_CNT;
`ifdef BOL_VIDEO_RX_TESTPAT_EN
    logic               TESTPAT = 1'b0;
`endif

    bol_video_rx #(
        .ADC_W(ADC_W), .DATA_DELAY(DLY), .WORDS_PER_ROW(WPR), .ROWS(NROWS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET), .DATAVALID(DATAVALID), .LINE1(LINE1),
        .ADC_IN1(ADC_IN1), .ADC_IN2(ADC_IN2),
`ifdef BOL_VIDEO_RX_TESTPAT_EN
        .TESTPAT(TESTPAT),
`endif
        .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL), .FRAME_CNT(FRAME_CNT),
        .ERR_OVF(ERR_OVF), .ERR_LEN(ERR_LEN), .ERR_CLR(ERR_CLR)
    );

    initial forever #5 CLK = ~CLK;

    exp_t                 exp_q[$];
    logic [2*ADC_W:0]     dq[$];
    logic [2*ADC_W-1:0]   row_w[$];
    int                   n_vec = 0, n_err = 0;
    int                   rdy_mode = 0;
    logic [15:0]          low_hist = '0;
    int                   k_ramp = 0;
    bit                   in_frame = 0;
    int                   rows_done = 0, exp_frames = 0;
    bit                   exp_len = 0, exp_ovf = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One input cycle; ADC words follow DATAVALID by DLY cycles, junk otherwise.
    task automatic tick(input logic dv, input logic l1, input logic [ADC_W-1:0] a1, input logic [ADC_W-1:0] a2);
        logic [2*ADC_W:0] e;
        logic r;
        @(posedge CLK); #1;
        ERR_CLR   = 1'b0;
        DATAVALID = dv;
        LINE1     = l1;
        dq.push_back({dv, a2, a1});
        e = '0;
        if (dq.size() > DLY) e = dq.pop_front();
        ADC_IN1 = e[2*ADC_W] ? e[ADC_W-1:0] : ADC_W'($urandom);
        ADC_IN2 = e[2*ADC_W] ? e[2*ADC_W-1:ADC_W] : ADC_W'($urandom);
        if (rdy_mode == 0)      r = 1'b1;
        else if (rdy_mode == 2) r = 1'b0;
        else r = !(($countones(low_hist) < 2) && ($urandom_range(0, 3) == 0));
        low_hist  = {low_hist[14:0], ~r};
        PIX_READY = r;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, '0, '0);
    endtask

    // Reference model: whole rows in, expected words out.
    task automatic model_row(input bit l1, input int len, input int keep);
        if (l1) begin
            if (in_frame) exp_len = 1;
            in_frame  = 1;
            rows_done = 0;
        end else if (!in_frame) begin
            return;
        end
        for (int i = 0; i < len && i < WPR; i++) begin
            if (i < keep) exp_q.push_back({row_w[i], (l1 && i == 0), (i == WPR - 1)});
            else          exp_ovf = 1;
        end
        if (len != WPR) exp_len = 1;
        rows_done++;
        if (rows_done == NROWS) begin
            exp_frames++;
            in_frame = 0;
        end
    endtask

    task automatic send_row(input bit l1, input int len, input int mode, input int keep, input bit use_model);
        row_w.delete();
        for (int i = 0; i < len; i++) begin
            if (mode == 0) row_w.push_back({ADC_W'(k_ramp + i + 16), ADC_W'(k_ramp + i)});
            else           row_w.push_back({ADC_W'($urandom), ADC_W'($urandom)});
        end
        k_ramp += len;
        if (use_model) model_row(l1, len, keep);
        for (int i = 0; i < len; i++) tick(1'b1, l1, row_w[i][ADC_W-1:0], row_w[i][2*ADC_W-1:ADC_W]);
        idle($urandom_range(3, 6));
    endtask

    task automatic send_frame(input int mode, input bit rand_len);
        int len;
        for (int r = 0; r < NROWS; r++) begin
            len = (rand_len && $urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : WPR;
            send_row(r == 0, len, mode, WPR, 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1'b0, 1'b0, '0, '0);
            n++;
        end
        chk("words_outstanding", exp_q.size(), 0);
        idle(4);
        chk("valid_after_drain", PIX_VALID, 0);
    endtask

    task automatic status();
        chk("frame_cnt", FRAME_CNT, exp_frames[15:0]);
        chk("err_len", ERR_LEN, exp_len);
        chk("err_ovf", ERR_OVF, exp_ovf);
    endtask

    task automatic clr_errors();
        tick(1'b0, 1'b0, '0, '0);
        ERR_CLR = 1'b1;
        tick(1'b0, 1'b0, '0, '0);
        exp_len = 0;
        exp_ovf = 0;
        idle(1);
        status();
    endtask

    // Monitor: every handshake pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET && PIX_VALID && PIX_READY) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", {PIX_DATA, PIX_SOF, PIX_EOL});
                end else begin
                    e = exp_q.pop_front();
                    chk("pix_word", {PIX_DATA, PIX_SOF, PIX_EOL}, e);
                end
            end
        end
    end

    initial begin
        RESET = 1'b1; DATAVALID = 1'b0; LINE1 = 1'b0; ADC_IN1 = '0; ADC_IN2 = '0;
        PIX_READY = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", PIX_VALID, 0);
        chk("rst_data", {PIX_DATA, PIX_SOF, PIX_EOL}, 0);
        status();
        RESET = 1'b0;
        idle(4);

        // Nominal ramp frame, ready always high
        k_ramp = 0;
        send_frame(0, 0);
        drain();
        status();
        chk("nominal_frames", FRAME_CNT, 1);

        // Random data, random row lengths, random back-pressure
        rdy_mode = 1;
        repeat (3) send_frame(1, 1);
        drain();
        status();
        clr_errors();
        rdy_mode = 0;

        // Short row then long row inside one frame
        send_row(1, WPR, 1, WPR, 1);
        send_row(0, 7, 1, WPR, 1);
        send_row(0, 10, 1, WPR, 1);
        send_row(0, WPR, 1, WPR, 1);
        drain();
        status();
        chk("short_row_err", ERR_LEN, 1);
        clr_errors();

        // Back-pressure for a whole row: first DEPTH words held, rest dropped
        send_row(1, WPR, 1, WPR, 1);
        drain();
        rdy_mode = 2;
        send_row(0, WPR, 1, DEPTH, 1);
        idle(DLY + 4);
        chk("held_valid", PIX_VALID, 1);
        chk("ovf_set", ERR_OVF, 1);
        status();
        rdy_mode = 0;
        drain();
        send_row(0, WPR, 1, WPR, 1);
        send_row(0, WPR, 1, WPR, 1);
        drain();
        status();
        clr_errors();

        // Short frame: LINE1 again after two rows
        send_row(1, WPR, 1, WPR, 1);
        send_row(0, WPR, 1, WPR, 1);
        send_row(1, WPR, 1, WPR, 1);
        idle(DLY + 4);
        status();
        chk("short_frame_err", ERR_LEN, 1);
        for (int r = 1; r < NROWS; r++) send_row(0, WPR, 1, WPR, 1);
        drain();
        status();
        clr_errors();

        // Reset mid-row: partial frame discarded
        rdy_mode = 2;
        send_row(1, WPR, 1, WPR, 0);
        idle(3);
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_mid_valid", PIX_VALID, 0);
        chk("rst_mid_frames", FRAME_CNT, 0);
        chk("rst_mid_ovf", ERR_OVF, 0);
        exp_q.delete();
        dq.delete();
        in_frame = 0; rows_done = 0; exp_frames = 0; exp_len = 0; exp_ovf = 0;
        DATAVALID = 1'b0; LINE1 = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        rdy_mode = 0;
        idle(5);
        send_row(0, WPR, 1, WPR, 1);
        idle(DLY + 4);
        chk("no_capture_wo_line1", PIX_VALID, 0);
        send_frame(1, 0);
        drain();
        status();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
